// File: rtl/team_07_spi_pkg.sv
// team_07_spi_pkg: shared state type, command layout constants and helpers
// for the team_07 SPI mode-0 target.
package team_07_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int DEF_ADDR_W = 4;

  // MSB-first serial shift: the newest bit enters at the LSB.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
    return {cur[6:0], bit_in};
  endfunction

endpackage

// File: rtl/team_07_spi_if.sv
// team_07_spi_if: SPI pad signals plus the core-side register port of the
// team_07 SPI target; master = initiator/core side, slave = the target.
interface team_07_spi_if
  import team_07_spi_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              en;
  logic              sclk_in;
  logic              cs_n_in;
  logic              mosi_in;
  logic              miso_out;
  logic              miso_oe;
  logic [ADDR_W-1:0] core_addr;
  logic [7:0]        core_wdata;
  logic              core_we;
  logic [7:0]        core_rdata;
  logic              spi_wr_valid;
  logic [ADDR_W-1:0] spi_wr_addr;
  logic [7:0]        spi_wr_data;
  logic              busy;

  modport master (
    output en, sclk_in, cs_n_in, mosi_in, core_addr, core_wdata, core_we,
    input  miso_out, miso_oe, core_rdata, spi_wr_valid, spi_wr_addr,
           spi_wr_data, busy
  );

  modport slave (
    input  en, sclk_in, cs_n_in, mosi_in, core_addr, core_wdata, core_we,
    output miso_out, miso_oe, core_rdata, spi_wr_valid, spi_wr_addr,
           spi_wr_data, busy
  );

endinterface

// File: rtl/team_07_sync_edge.sv
// team_07_sync_edge: multi-flop synchronizer for an asynchronous pad signal,
// followed by one history flop that yields single-clk rise/fall pulses.
module team_07_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // RESET_VAL lets an idle-high line such as cs_n come out of reset without a false edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/team_07_spi_target.sv
// team_07_spi_target: oversampled SPI mode-0 target exposing a 2^ADDR_W x 8
// register file. Define SPI_TGT_AUTOINC_EN to auto-increment the address per data byte.
module team_07_spi_target
  import team_07_spi_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          nrst,
  team_07_spi_if.slave bus
);

  logic sclk_rise, sclk_fall, unused_sclk_level;
  logic cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_sync;

  spi_state_t state, next_state;

  logic [2:0]        bit_cnt;
  logic [7:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [7:0]        rx_byte;
  logic              miso_q;
  logic              oe_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        regs [2**ADDR_W];
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        rdata_q;

  logic abort, cmd_done, byte_done, shift_out;

  team_07_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk      (clk),
    .nrst     (nrst),
    .async_in (bus.sclk_in),
    .sync_out (unused_sclk_level),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  team_07_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .nrst     (nrst),
    .async_in (bus.cs_n_in),
    .sync_out (cs_sync),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // mosi carries the same latency as sclk so it lines up with the rise pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) mosi_q <= '0;
    else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi_in};
  end
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

`ifdef SPI_TGT_AUTOINC_EN
  assign next_addr = addr_q + 1'b1;
`else
  assign next_addr = addr_q;
`endif

  assign cmd_addr = rx_byte[ADDR_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.en && cs_fall) next_state = CMD;
      CMD: begin
        if (abort)         next_state = IDLE;
        else if (cmd_done) next_state = DATA;
      end
      DATA: if (abort) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    abort     = cs_rise | ~bus.en;
    rx_byte   = shift_in(rx_shift, mosi_sync);
    cmd_done  = 1'b0;
    byte_done = 1'b0;
    shift_out = 1'b0;
    bus.busy  = (state != IDLE);
    case (state)
      CMD:  cmd_done = ~abort & sclk_rise & (bit_cnt == 3'd7);
      DATA: begin
        byte_done = ~abort & sclk_rise & (bit_cnt == 3'd7);
        shift_out = ~abort & sclk_fall & rw_q;
      end
      default: ;
    endcase
  end

  // An abort drops any partial byte; the command fields are simply overwritten next time.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso_q   <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
    end else if (state == IDLE || abort) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso_q   <= 1'b0;
    end else begin
      if (sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte;
      end
      if (cmd_done) begin
        rw_q   <= rx_byte[CMD_RW_BIT];
        addr_q <= cmd_addr;
        if (rx_byte[CMD_RW_BIT]) tx_shift <= regs[cmd_addr];
      end
      if (byte_done) begin
        addr_q <= next_addr;
        if (rw_q) tx_shift <= regs[next_addr];
      end
      if (shift_out) begin
        miso_q   <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  // The SPI write is the later assignment so it wins a same-clk core write collision.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (bus.core_we) regs[bus.core_addr] <= bus.core_wdata;
      if (byte_done && !rw_q) begin
        regs[addr_q] <= rx_byte;
        wr_valid_q   <= 1'b1;
        wr_addr_q    <= addr_q;
        wr_data_q    <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      rdata_q <= regs[bus.core_addr];
      oe_q    <= ~cs_sync & bus.en;
    end
  end

  assign bus.miso_oe      = oe_q;
  assign bus.miso_out     = oe_q & miso_q;
  assign bus.core_rdata   = rdata_q;
  assign bus.spi_wr_valid = wr_valid_q;
  assign bus.spi_wr_addr  = wr_addr_q;
  assign bus.spi_wr_data  = wr_data_q;

endmodule

// File: tb/tb_team_07_spi_target.sv
// tb_team_07_spi_target: directed SPI initiator and core-port bench for
// team_07_spi_target; expectations follow SPI_TGT_AUTOINC_EN when defined.
module tb_team_07_spi_target;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  team_07_spi_if #(.ADDR_W(4)) bus ();

  team_07_spi_target #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int         wr_cycles = 0;
  logic [3:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  // Counts every clk spi_wr_valid is high, so a single pulse adds exactly one.
  always @(negedge clk) begin
    if (bus.spi_wr_valid === 1'b1) begin
      wr_cycles++;
      last_wr_addr = bus.spi_wr_addr;
      last_wr_data = bus.spi_wr_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI byte (or its first nbits), mode 0; optionally fires a core write
  // to reg7 on the same clk the target acts on the final sclk rise.
  task automatic applyStimulus(input logic [7:0] tx, input int nbits, input bit collide,
                               output logic [7:0] rx, output bit stable);
    rx = '0;
    stable = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.mosi_in = tx[i];
      wait_clks(HALF);
      bus.sclk_in = 1'b1;
      rx[i] = bus.miso_out;
      if (collide && i == 0) begin
        wait_clks(2);
        bus.core_addr  = 4'd7;
        bus.core_wdata = 8'hAA;
        bus.core_we    = 1'b1;
        wait_clks(1);
        bus.core_we    = 1'b0;
        wait_clks(1);
      end else begin
        wait_clks(4);
      end
      if (bus.miso_out !== rx[i]) stable = 1'b0;
      wait_clks(HALF - 4);
      bus.sclk_in = 1'b0;
    end
  endtask

  task automatic cs_start();
    bus.cs_n_in = 1'b0;
  endtask

  task automatic cs_end();
    wait_clks(HALF);
    bus.cs_n_in = 1'b1;
    wait_clks(6);
  endtask

  task automatic core_write(input logic [3:0] a, input logic [7:0] d);
    bus.core_addr  = a;
    bus.core_wdata = d;
    bus.core_we    = 1'b1;
    wait_clks(1);
    bus.core_we    = 1'b0;
  endtask

  task automatic core_read(input logic [3:0] a, output logic [7:0] d);
    bus.core_addr = a;
    wait_clks(2);
    d = bus.core_rdata;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] rd;
    bit         stable;
    int         w0;

    bus.en         = 1'b1;
    bus.sclk_in    = 1'b0;
    bus.cs_n_in    = 1'b1;
    bus.mosi_in    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.core_we    = 1'b0;
    wait_clks(3);
    nrst = 1'b1;
    wait_clks(3);

    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_miso_oe", bus.miso_oe, 0);
    checkOutput("rst_miso_out", bus.miso_out, 0);
    checkOutput("rst_wr_valid", bus.spi_wr_valid, 0);
    core_read(4'd3, rd);
    checkOutput("rst_reg3", rd, 8'h00);

    $display("[TB] write cmd 0x03 data 0xA5");
    w0 = wr_cycles;
    cs_start();
    applyStimulus(8'h03, 8, 1'b0, rx, stable);
    checkOutput("t1_busy", bus.busy, 1);
    checkOutput("t1_miso_oe", bus.miso_oe, 1);
    applyStimulus(8'hA5, 8, 1'b0, rx, stable);
    cs_end();
    checkOutput("t1_pulses", wr_cycles - w0, 1);
    checkOutput("t1_wr_addr", last_wr_addr, 4'd3);
    checkOutput("t1_wr_data", last_wr_data, 8'hA5);
    core_read(4'd3, rd);
    checkOutput("t1_reg3", rd, 8'hA5);
    checkOutput("t1_idle_busy", bus.busy, 0);

    $display("[TB] core writes reg5/reg6, SPI burst read cmd 0x85");
    core_write(4'd5, 8'h3C);
    core_write(4'd6, 8'hC3);
    w0 = wr_cycles;
    cs_start();
    applyStimulus(8'h85, 8, 1'b0, rx, stable);
    checkOutput("t2_cmd_miso", rx, 8'h00);
    applyStimulus(8'h00, 8, 1'b0, rx, stable);
    checkOutput("t2_byte0", rx, 8'h3C);
    checkOutput("t2_stable0", stable, 1);
    applyStimulus(8'h00, 8, 1'b0, rx, stable);
`ifdef SPI_TGT_AUTOINC_EN
    checkOutput("t2_byte1", rx, 8'hC3);
`else
    checkOutput("t2_byte1", rx, 8'h3C);
`endif
    checkOutput("t2_stable1", stable, 1);
    cs_end();
    checkOutput("t2_no_write", wr_cycles - w0, 0);
    checkOutput("t2_oe_off", bus.miso_oe, 0);

    $display("[TB] write burst cmd 0x0F data 0x11,0x22");
    w0 = wr_cycles;
    cs_start();
    applyStimulus(8'h0F, 8, 1'b0, rx, stable);
    applyStimulus(8'h11, 8, 1'b0, rx, stable);
    applyStimulus(8'h22, 8, 1'b0, rx, stable);
    cs_end();
    checkOutput("t3_pulses", wr_cycles - w0, 2);
    core_read(4'd15, rd);
`ifdef SPI_TGT_AUTOINC_EN
    checkOutput("t3_reg15", rd, 8'h11);
    core_read(4'd0, rd);
    checkOutput("t3_reg0", rd, 8'h22);
    checkOutput("t3_last_addr", last_wr_addr, 4'd0);
`else
    checkOutput("t3_reg15", rd, 8'h22);
    core_read(4'd0, rd);
    checkOutput("t3_reg0", rd, 8'h00);
    checkOutput("t3_last_addr", last_wr_addr, 4'd15);
`endif

    $display("[TB] write cmd 0x02 aborted after 4 data bits");
    core_write(4'd2, 8'h77);
    w0 = wr_cycles;
    cs_start();
    applyStimulus(8'h02, 8, 1'b0, rx, stable);
    applyStimulus(8'hF0, 4, 1'b0, rx, stable);
    bus.cs_n_in = 1'b1;
    wait_clks(4);
    checkOutput("t4_busy", bus.busy, 0);
    wait_clks(4);
    checkOutput("t4_no_pulse", wr_cycles - w0, 0);
    core_read(4'd2, rd);
    checkOutput("t4_reg2", rd, 8'h77);

    $display("[TB] en dropped during SPI read, then fresh write");
    cs_start();
    applyStimulus(8'h85, 8, 1'b0, rx, stable);
    applyStimulus(8'h00, 3, 1'b0, rx, stable);
    checkOutput("t5_partial", rx, 8'h20);
    bus.en = 1'b0;
    wait_clks(2);
    checkOutput("t5_oe", bus.miso_oe, 0);
    checkOutput("t5_miso", bus.miso_out, 0);
    checkOutput("t5_busy", bus.busy, 0);
    bus.cs_n_in = 1'b1;
    wait_clks(4);
    bus.en = 1'b1;
    wait_clks(4);
    core_read(4'd5, rd);
    checkOutput("t5_reg5_kept", rd, 8'h3C);
    w0 = wr_cycles;
    cs_start();
    applyStimulus(8'h09, 8, 1'b0, rx, stable);
    applyStimulus(8'h9C, 8, 1'b0, rx, stable);
    cs_end();
    checkOutput("t5_pulses", wr_cycles - w0, 1);
    core_read(4'd9, rd);
    checkOutput("t5_reg9", rd, 8'h9C);

    $display("[TB] SPI write reg7=0x55 colliding with core write 0xAA");
    w0 = wr_cycles;
    cs_start();
    applyStimulus(8'h07, 8, 1'b0, rx, stable);
    applyStimulus(8'h55, 8, 1'b1, rx, stable);
    cs_end();
    checkOutput("t6_pulses", wr_cycles - w0, 1);
    checkOutput("t6_wr_data", last_wr_data, 8'h55);
    core_read(4'd7, rd);
    checkOutput("t6_reg7", rd, 8'h55);
    core_write(4'd7, 8'h66);
    core_read(4'd7, rd);
    checkOutput("t6_core_path", rd, 8'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
